// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Provides the {pc, instr} bundle carried through the prefetch FIFO.
package imem_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
    localparam logic [ILEN-1:0] INSN_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t; flush beats push and empties it.
// Ports: push_i/pop_i/flush_i control, wdata_i in, rdata_o head, count_o occupancy.
module fetch_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               wdata_i,
    output fetch_entry_t               rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t        mem_q [DEPTH];
    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       rptr_q, rptr_d;
    logic [CW-1:0]       count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            // Leave the read pointer alone so the stale head keeps
            // presenting its last value while the FIFO is empty.
            wptr_d  = rptr_q;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + 1'b1;
            if (pop_i)  rptr_d = rptr_q + 1'b1;
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: drives iaddr from the fetch PC, buffers {pc, instr} pairs,
// and hands them to decode. Ports: en/redirect_* control, iaddr/idata memory,
// out_valid/out_ready/out_pc/out_instr decode side, misalign and fifo_count status.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic [31:0]            iaddr,
    input  logic [31:0]            idata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_instr,
    output logic                   misalign,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            misalign_q, misalign_d;
    logic            push, pop;
    logic [CW-1:0]   count;
    fetch_entry_t    wdata, head;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A pop on the same edge frees a slot, so a full FIFO still streams.
    assign push      = en & ~misalign_q & ~redirect_valid
                     & ((count < CW'(DEPTH)) | pop);

    assign wdata.pc    = fetch_pc_q;
    assign wdata.instr = idata;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        misalign_d = misalign_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            misalign_d = |redirect_pc[1:0];
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wdata),
        .rdata_o (head),
        .count_o (count)
    );

    assign iaddr      = fetch_pc_q;
    assign out_pc     = head.pc;
    assign out_instr  = head.instr;
    assign misalign   = misalign_q;
    assign fifo_count = count;

endmodule
